pc_sequencer: RTL and testbench

Program-counter sequencer for the 16-bit core, sitting directly downstream of the flag register. It owns the PC, issues instruction-fetch requests, waits for the datapath to finish each instruction, and resolves conditional branches from the registered Low/Negative/Zero flags. Every instruction takes at least two cycles: one to fetch and one or more to execute.

---
 rtl/pc_sequencer_pkg.sv | 34 +++
 rtl/pc_sequencer_cond_eval.sv | 38 +++
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : State, condition-code and branch-kind encodings for the PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] c_COND_EQ = 4'd0;
    localparam logic [3:0] c_COND_NE = 4'd1;
    localparam logic [3:0] c_COND_LO = 4'd2;
    localparam logic [3:0] c_COND_HS = 4'd3;
    localparam logic [3:0] c_COND_LT = 4'd4;
    localparam logic [3:0] c_COND_GE = 4'd5;
    localparam logic [3:0] c_COND_HI = 4'd6;
    localparam logic [3:0] c_COND_LS = 4'd7;
    localparam logic [3:0] c_COND_GT = 4'd8;
    localparam logic [3:0] c_COND_LE = 4'd9;
    localparam logic [3:0] c_COND_UC = 4'd14;

    localparam logic c_BR_KIND_REL = 1'b0;
    localparam logic c_BR_KIND_ABS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_cond_eval.sv
// ============================================================================
// Module   : cond_eval
// Brief    : Combinational condition-code evaluator over the L/N/Z flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [3:0] br_cond,
    input  logic       flag_low,
    input  logic       flag_negative,
    input  logic       flag_zero,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            c_COND_EQ: cond_true = flag_zero;
            c_COND_NE: cond_true = !flag_zero;
            c_COND_LO: cond_true = flag_low;
            c_COND_HS: cond_true = !flag_low;
            c_COND_LT: cond_true = flag_negative;
            c_COND_GE: cond_true = !flag_negative;
            c_COND_HI: cond_true = !flag_low && !flag_zero;
            c_COND_LS: cond_true = flag_low || flag_zero;
            c_COND_GT: cond_true = !flag_negative && !flag_zero;
            c_COND_LE: cond_true = flag_negative || flag_zero;
            c_COND_UC: cond_true = 1'b1;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Owns the PC, issues fetches, waits for execution and resolves branches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_low,
    input  logic              flag_negative,
    input  logic              flag_zero,
    input  logic              fetch_ack,
    input  logic              exec_done,
    input  logic              br_valid,
    input  logic              br_kind,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_operand,
    input  logic              halt_req,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              exec_en,
    output logic              branch_taken,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_branch_taken;
    logic              w_branch_taken_nxt;
    logic              w_cond_true;
    logic [ADDR_W-1:0] w_target;

    cond_eval u_cond_eval (
        .br_cond       (br_cond),
        .flag_low      (flag_low),
        .flag_negative (flag_negative),
        .flag_zero     (flag_zero),
        .cond_true     (w_cond_true)
    );

    // Both the relative sum and the sequential increment wrap modulo 2^ADDR_W.
    assign w_target = (br_kind == c_BR_KIND_ABS) ? br_operand : (r_pc + br_operand);

    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_branch_taken_nxt = 1'b0;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: if (fetch_ack) w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (exec_done) begin
                    if (halt_req) begin
                        w_state_nxt = ST_HALT;
                    end else if (br_valid && w_cond_true) begin
                        w_state_nxt        = ST_FETCH;
                        w_pc_nxt           = w_target;
                        w_branch_taken_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_pc_nxt    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_branch_taken <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_branch_taken <= w_branch_taken_nxt;
        end
    end

    assign fetch_req    = (r_state == ST_FETCH);
    assign exec_en      = (r_state == ST_EXEC);
    assign halted       = (r_state == ST_HALT);
    assign fetch_addr   = r_pc;
    assign pc           = r_pc;
    assign branch_taken = r_branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flag_low = 1'b0;
    logic        flag_negative = 1'b0;
    logic        flag_zero = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_kind = 1'b0;
    logic [3:0]  br_cond = 4'd0;
    logic [15:0] br_operand = 16'h0000;
    logic        halt_req = 1'b0;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        exec_en;
    logic        branch_taken;
    logic        halted;
    logic [15:0] pc;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .flag_low      (flag_low),
        .flag_negative (flag_negative),
        .flag_zero     (flag_zero),
        .fetch_ack     (fetch_ack),
        .exec_done     (exec_done),
        .br_valid      (br_valid),
        .br_kind       (br_kind),
        .br_cond       (br_cond),
        .br_operand    (br_operand),
        .halt_req      (halt_req),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .exec_en       (exec_en),
        .branch_taken  (branch_taken),
        .halted        (halted),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch();
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
    endtask

    task automatic do_exec(input logic bv, input logic kind, input logic [3:0] cond,
                           input logic [15:0] op, input logic hlt,
                           input logic l, input logic n, input logic z);
        br_valid = bv; br_kind = kind; br_cond = cond; br_operand = op;
        halt_req = hlt; flag_low = l; flag_negative = n; flag_zero = z;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0; br_valid = 1'b0; halt_req = 1'b0;
    endtask

    function automatic logic exp_cond(input int c, input logic l, input logic n, input logic z);
        case (c)
            0:  return z;
            1:  return !z;
            2:  return l;
            3:  return !l;
            4:  return n;
            5:  return !n;
            6:  return !l && !z;
            7:  return l || z;
            8:  return !n && !z;
            9:  return n || z;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({fetch_req, exec_en, halted, branch_taken} !== 4'b0000 || pc !== 16'h0000)
            $display("FAIL reset_state: req/exec/halt/bt=%b pc=%h, want 0000 pc=0000",
                     {fetch_req, exec_en, halted, branch_taken}, pc);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (fetch_req !== 1'b0) $display("FAIL boot_cycle: fetch_req=%b want 0", fetch_req);
        else n_pass++;
        step();
        n_checks++;
        if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000)
            $display("FAIL first_fetch: req=%b addr=%h want 1 0000", fetch_req, fetch_addr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000)
                $display("FAIL fetch_hold: req=%b addr=%h want 1 0000", fetch_req, fetch_addr);
            else n_pass++;
        end
        do_fetch();
        n_checks++;
        if (exec_en !== 1'b1 || fetch_req !== 1'b0)
            $display("FAIL exec_entry: exec_en=%b req=%b want 1 0", exec_en, fetch_req);
        else n_pass++;
        do_exec(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fetch_req !== 1'b1 || fetch_addr !== 16'h0001 || branch_taken !== 1'b0)
            $display("FAIL seq_step: req=%b addr=%h bt=%b want 1 0001 0",
                     fetch_req, fetch_addr, branch_taken);
        else n_pass++;
    endtask

    task automatic test_ignore();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        n_checks++;
        if (fetch_req !== 1'b1 || exec_en !== 1'b0 || pc !== 16'h0001)
            $display("FAIL done_in_fetch: req=%b exec=%b pc=%h want 1 0 0001", fetch_req, exec_en, pc);
        else n_pass++;
        do_fetch();
        fetch_ack = 1'b1; br_valid = 1'b1; br_cond = 4'd14; halt_req = 1'b1;
        repeat (2) step();
        fetch_ack = 1'b0; br_valid = 1'b0; halt_req = 1'b0;
        n_checks++;
        if (exec_en !== 1'b1 || pc !== 16'h0001 || halted !== 1'b0)
            $display("FAIL exec_stall: exec=%b pc=%h halted=%b want 1 0001 0", exec_en, pc, halted);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_exec(1'b1, 1'b1, 4'd14, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fetch_addr !== 16'hFFFF || branch_taken !== 1'b1)
            $display("FAIL abs_to_ffff: addr=%h bt=%b want ffff 1", fetch_addr, branch_taken);
        else n_pass++;
        do_fetch();
        n_checks++;
        if (branch_taken !== 1'b0) $display("FAIL bt_one_cycle: bt=%b want 0", branch_taken);
        else n_pass++;
        do_exec(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fetch_addr !== 16'h0000) $display("FAIL pc_wrap: addr=%h want 0000", fetch_addr);
        else n_pass++;
    endtask

    task automatic test_relative();
        do_fetch();
        do_exec(1'b1, 1'b1, 4'd14, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch();
        do_exec(1'b1, 1'b0, 4'd0, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (fetch_addr !== 16'h000C || branch_taken !== 1'b1)
            $display("FAIL rel_taken: addr=%h bt=%b want 000c 1", fetch_addr, branch_taken);
        else n_pass++;
        do_fetch();
        n_checks++;
        if (branch_taken !== 1'b0) $display("FAIL rel_pulse_width: bt=%b want 0", branch_taken);
        else n_pass++;
        do_exec(1'b1, 1'b1, 4'd14, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch();
        do_exec(1'b1, 1'b0, 4'd0, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fetch_addr !== 16'h0011 || branch_taken !== 1'b0)
            $display("FAIL rel_not_taken: addr=%h bt=%b want 0011 0", fetch_addr, branch_taken);
        else n_pass++;
    endtask

    task automatic test_cond_sweep();
        logic [15:0] exp_pc;
        logic        t;
        logic        l, n, z;
        exp_pc = 16'h0011;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 8; f++) begin
                l = f[2]; n = f[1]; z = f[0];
                t = exp_cond(c, l, n, z);
                exp_pc = t ? 16'h0100 : exp_pc + 16'h0001;
                do_fetch();
                do_exec(1'b1, 1'b1, 4'(c), 16'h0100, 1'b0, l, n, z);
                n_checks++;
                if (branch_taken !== t || pc !== exp_pc)
                    $display("FAIL cond_sweep c=%0d lnz=%b%b%b: bt=%b pc=%h want %b %h",
                             c, l, n, z, branch_taken, pc, t, exp_pc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_jump_halt();
        do_fetch();
        do_exec(1'b1, 1'b1, 4'd14, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fetch_addr !== 16'h1234) $display("FAIL uc_jump: addr=%h want 1234", fetch_addr);
        else n_pass++;
        do_fetch();
        do_exec(1'b1, 1'b1, 4'd14, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (halted !== 1'b1 || pc !== 16'h1234 || branch_taken !== 1'b0)
            $display("FAIL halt_entry: halted=%b pc=%h bt=%b want 1 1234 0", halted, pc, branch_taken);
        else n_pass++;
        fetch_ack = 1'b1;
        exec_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (fetch_req !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b1 || pc !== 16'h1234)
                $display("FAIL halt_hold: req=%b exec=%b halted=%b pc=%h want 0 0 1 1234",
                         fetch_req, exec_en, halted, pc);
            else n_pass++;
        end
        fetch_ack = 1'b0;
        exec_done = 1'b0;
    endtask

    task automatic test_mid_reset();
        reset = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0 || pc !== 16'h0000)
            $display("FAIL halt_reset: halted=%b pc=%h want 0 0000", halted, pc);
        else n_pass++;
        step();
        reset = 1'b1;
        step();
        do_fetch();
        do_exec(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch();
        n_checks++;
        if (exec_en !== 1'b1 || pc !== 16'h0001)
            $display("FAIL pre_reset_exec: exec=%b pc=%h want 1 0001", exec_en, pc);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pc !== 16'h0000 || fetch_req !== 1'b0 || exec_en !== 1'b0)
            $display("FAIL async_reset: pc=%h req=%b exec=%b want 0000 0 0", pc, fetch_req, exec_en);
        else n_pass++;
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (fetch_req !== 1'b0 || exec_en !== 1'b0)
            $display("FAIL restart_boot: req=%b exec=%b want 0 0", fetch_req, exec_en);
        else n_pass++;
        step();
        n_checks++;
        if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000)
            $display("FAIL restart_fetch: req=%b addr=%h want 1 0000", fetch_req, fetch_addr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_wrap();
        test_relative();
        test_cond_sweep();
        test_jump_halt();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
